interval_monitor_sequencer: RTL and testbench

INTERVAL_MONITOR_SEQUENCER -- requirements
Module: interval_monitor_sequencer

---
 rtl/interval_seq_pkg.sv | 28 ++
 rtl/interval_seq_dwell_counter.sv | 40 ++++
 rtl/interval_monitor_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_interval_monitor_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_seq_pkg.sv
// interval_seq_pkg
//   Shared definitions for the interval monitor sequencer:
//   - state_t          : sequencer FSM state encoding (also driven out on state_dbg)
//   - RST_LOWER_BOUND  : checker lower bound presented while in reset
//   - RST_UPPER_BOUND  : checker upper bound presented while in reset
//   - TIMEOUT_FLAG     : slot result written when a RUN phase times out
//   - dwell_target()   : dwell count with zero promoted to one
package interval_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_NEXT    = 3'd5
  } state_t;

  localparam logic [31:0] RST_LOWER_BOUND = 32'h0033_0000;
  localparam logic [31:0] RST_UPPER_BOUND = 32'h0034_0000;
  localparam logic [31:0] TIMEOUT_FLAG    = 32'h4000_0000;

  // A dwell of zero still needs one qualifying tag to finish a RUN phase.
  function automatic logic [31:0] dwell_target(input logic [31:0] dwell);
    return (dwell == 32'd0) ? 32'd1 : dwell;
  endfunction

endpackage

// File: rtl/interval_seq_dwell_counter.sv
// interval_seq_dwell_counter
//   32-bit saturating event counter used for both the tag dwell count and the
//   per-phase cycle count (settle, run timeout, capture).
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset, clears the count
//   clr_i  in   synchronous clear, wins over inc_i
//   inc_i  in   increment by one; holds at 32'hFFFF_FFFF
//   cnt_o  out  current count (registered)
module interval_seq_dwell_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 32'd0;
    end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/interval_monitor_sequencer.sv
// interval_monitor_sequencer
//   Sweeps an external interval checker across NUM_SLOTS channel slots. For each
//   slot it loads the slot's channel and bounds onto the checker, holds the
//   checker in reset for SETTLE_CYC cycles, releases it until dwell_tags tags
//   have been seen on that channel, waits CAPTURE_CYC cycles, then latches the
//   checker's failed word into that slot's result.
//
// Optional feature: INTERVAL_SEQ_TIMEOUT_EN adds input timeout_cycles; a RUN
//   phase lasting that many cycles without reaching the dwell count records
//   TIMEOUT_FLAG for the slot and moves on. timeout_cycles == 0 disables it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              level; high runs sweeps, low aborts to IDLE
//   valid_tag, channel  tag strobe (single cycle, no back-pressure) + channel
//   slot_channel        5 bits per slot, slot s at [5*s +: 5]
//   slot_lower/upper    32 bits per slot, slot s at [32*s +: 32]
//   dwell_tags          tags per slot, sampled in LOAD
//   chk_failed          checker result word (bit31 = valid)
//   timeout_cycles      RUN timeout (only with INTERVAL_SEQ_TIMEOUT_EN)
//   chk_hold            checker reset hold
//   chk_channel_select  zero-extended active slot channel
//   chk_lower/upper_bound  active slot bounds
//   slot_failed         latched results, slot s at [32*s +: 32]
//   slot_idx            active slot
//   busy                high outside IDLE
//   sweep_done          one-cycle pulse in the NEXT cycle that wraps slot_idx
//   state_dbg           current FSM state
module interval_monitor_sequencer
  import interval_seq_pkg::*;
#(
  parameter  int NUM_SLOTS   = 4,
  parameter  int SETTLE_CYC  = 6,
  parameter  int CAPTURE_CYC = 3,
  localparam int IDX_W       = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   valid_tag,
  input  logic [4:0]             channel,
  input  logic [5*NUM_SLOTS-1:0]  slot_channel,
  input  logic [32*NUM_SLOTS-1:0] slot_lower,
  input  logic [32*NUM_SLOTS-1:0] slot_upper,
  input  logic [31:0]            dwell_tags,
  input  logic [31:0]            chk_failed,
`ifdef INTERVAL_SEQ_TIMEOUT_EN
  input  logic [31:0]            timeout_cycles,
`endif
  output logic                   chk_hold,
  output logic [31:0]            chk_channel_select,
  output logic [31:0]            chk_lower_bound,
  output logic [31:0]            chk_upper_bound,
  output logic [32*NUM_SLOTS-1:0] slot_failed,
  output logic [IDX_W-1:0]       slot_idx,
  output logic                   busy,
  output logic                   sweep_done,
  output state_t                 state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  state_t                  state_q;
  logic [IDX_W-1:0]        slot_idx_q;
  logic [32*NUM_SLOTS-1:0] slot_failed_q;
  logic                    chk_hold_q;
  logic                    busy_q;
  logic                    sweep_done_q;
  logic [31:0]             chk_channel_q;
  logic [31:0]             chk_lower_q;
  logic [31:0]             chk_upper_q;
  logic [31:0]             dwell_q;

  // Configuration of the slot currently addressed by slot_idx_q.
  logic [4:0]  cur_ch;
  logic [31:0] cur_lo;
  logic [31:0] cur_hi;

  always_comb begin
    cur_ch = 5'd0;
    cur_lo = 32'd0;
    cur_hi = 32'd0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_idx_q == IDX_W'(s)) begin
        cur_ch = slot_channel[5*s +: 5];
        cur_lo = slot_lower[32*s +: 32];
        cur_hi = slot_upper[32*s +: 32];
      end
    end
  end

  // Counters: tag count lives only in RUN; the cycle count measures time
  // spent in the current SETTLE/RUN/CAPTURE phase and restarts on each exit.
  logic [31:0] tag_cnt;
  logic [31:0] cyc_cnt;
  logic        tag_hit;
  logic        run_done;
  logic        settle_last;
  logic        capture_last;
  logic        last_slot;
  logic        in_timed;
  logic        abort;

  assign tag_hit      = valid_tag && (channel == chk_channel_q[4:0]);
  // Includes this cycle's tag so a hit on the final needed cycle ends RUN now.
  assign run_done     = ({1'b0, tag_cnt} + {32'd0, tag_hit}) >= {1'b0, dwell_q};
  assign settle_last  = (cyc_cnt == 32'(SETTLE_CYC - 1));
  assign capture_last = (cyc_cnt == 32'(CAPTURE_CYC - 1));
  assign last_slot    = (slot_idx_q == LAST_IDX);
  assign in_timed     = (state_q == ST_SETTLE) || (state_q == ST_RUN) || (state_q == ST_CAPTURE);
  assign abort        = !enable && (in_timed || (state_q == ST_LOAD));

`ifdef INTERVAL_SEQ_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (timeout_cycles != 32'd0) && (cyc_cnt == timeout_cycles - 32'd1);
`endif

  interval_seq_dwell_counter u_tag_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != ST_RUN),
    .inc_i ((state_q == ST_RUN) && tag_hit),
    .cnt_o (tag_cnt)
  );

  interval_seq_dwell_counter u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_timed || ((state_q == ST_SETTLE) && settle_last) ||
            ((state_q == ST_RUN) && run_done)),
    .inc_i (in_timed),
    .cnt_o (cyc_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      slot_idx_q    <= '0;
      slot_failed_q <= '0;
      chk_hold_q    <= 1'b1;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      chk_channel_q <= 32'd0;
      chk_lower_q   <= RST_LOWER_BOUND;
      chk_upper_q   <= RST_UPPER_BOUND;
      dwell_q       <= 32'd1;
    end else begin
      sweep_done_q <= 1'b0;
      if (abort) begin
        // Abort keeps slot_idx and results so a re-enable resumes this slot.
        state_q    <= ST_IDLE;
        chk_hold_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (enable) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            chk_channel_q <= {27'd0, cur_ch};
            chk_lower_q   <= cur_lo;
            chk_upper_q   <= cur_hi;
            dwell_q       <= dwell_target(dwell_tags);
            state_q       <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_last) begin
              state_q    <= ST_RUN;
              chk_hold_q <= 1'b0;
            end
          end
          ST_RUN: begin
            if (run_done) begin
              state_q <= ST_CAPTURE;
            end
`ifdef INTERVAL_SEQ_TIMEOUT_EN
            else if (timeout_hit) begin
              for (int s = 0; s < NUM_SLOTS; s++) begin
                if (slot_idx_q == IDX_W'(s)) slot_failed_q[32*s +: 32] <= TIMEOUT_FLAG;
              end
              state_q      <= ST_NEXT;
              chk_hold_q   <= 1'b1;
              sweep_done_q <= last_slot;
            end
`endif
          end
          ST_CAPTURE: begin
            if (capture_last) begin
              for (int s = 0; s < NUM_SLOTS; s++) begin
                if (slot_idx_q == IDX_W'(s)) slot_failed_q[32*s +: 32] <= chk_failed;
              end
              state_q      <= ST_NEXT;
              chk_hold_q   <= 1'b1;
              sweep_done_q <= last_slot;
            end
          end
          ST_NEXT: begin
            slot_idx_q <= last_slot ? '0 : slot_idx_q + 1'b1;
            if (enable) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            chk_hold_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chk_hold           = chk_hold_q;
  assign chk_channel_select = chk_channel_q;
  assign chk_lower_bound    = chk_lower_q;
  assign chk_upper_bound    = chk_upper_q;
  assign slot_failed        = slot_failed_q;
  assign slot_idx           = slot_idx_q;
  assign busy               = busy_q;
  assign sweep_done         = sweep_done_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_interval_monitor_sequencer.sv
// tb_interval_monitor_sequencer
//   Directed bench for interval_monitor_sequencer with NUM_SLOTS=2. A small
//   checker model drives chk_failed from the presented bounds and the bench's
//   current tag interval. With INTERVAL_SEQ_TIMEOUT_EN defined it also
//   exercises the RUN timeout.
module tb_interval_monitor_sequencer;
  import interval_seq_pkg::*;

  localparam int NS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                 enable = 1'b0;
  logic                 valid_tag = 1'b0;
  logic [4:0]           channel = 5'd0;
  logic [5*NS-1:0]      slot_channel = '0;
  logic [32*NS-1:0]     slot_lower = '0;
  logic [32*NS-1:0]     slot_upper = '0;
  logic [31:0]          dwell_tags = 32'd0;
  logic [31:0]          chk_failed;
`ifdef INTERVAL_SEQ_TIMEOUT_EN
  logic [31:0]          timeout_cycles = 32'd0;
`endif
  logic                 chk_hold;
  logic [31:0]          chk_channel_select;
  logic [31:0]          chk_lower_bound;
  logic [31:0]          chk_upper_bound;
  logic [32*NS-1:0]     slot_failed;
  logic [$clog2(NS)-1:0] slot_idx;
  logic                 busy;
  logic                 sweep_done;
  state_t               state_dbg;

  interval_monitor_sequencer #(
    .NUM_SLOTS   (NS),
    .SETTLE_CYC  (6),
    .CAPTURE_CYC (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .valid_tag          (valid_tag),
    .channel            (channel),
    .slot_channel       (slot_channel),
    .slot_lower         (slot_lower),
    .slot_upper         (slot_upper),
    .dwell_tags         (dwell_tags),
    .chk_failed         (chk_failed),
`ifdef INTERVAL_SEQ_TIMEOUT_EN
    .timeout_cycles     (timeout_cycles),
`endif
    .chk_hold           (chk_hold),
    .chk_channel_select (chk_channel_select),
    .chk_lower_bound    (chk_lower_bound),
    .chk_upper_bound    (chk_upper_bound),
    .slot_failed        (slot_failed),
    .slot_idx           (slot_idx),
    .busy               (busy),
    .sweep_done         (sweep_done),
    .state_dbg          (state_dbg)
  );

  // ---------------- checker model ----------------
  logic [31:0] tag_interval = 32'd0;

  function automatic logic [31:0] chk_model(input logic [31:0] iv, input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (iv > hi) return 32'h8000_0000 | (iv - hi);
    if (iv < lo) return 32'h8000_0000 | (lo - iv);
    return 32'd0;
  endfunction

  always_comb chk_failed = chk_hold ? 32'd0 : chk_model(tag_interval, chk_lower_bound, chk_upper_bound);

  // ---------------- scoreboard ----------------
  int n_checks  = 0;
  int n_fail    = 0;
  int sweep_cnt = 0;
  int n_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (sweep_done === 1'b1) sweep_cnt++;
  endtask

  task automatic wait_state(input state_t st, input int maxc, input string tag);
    int n;
    n = 0;
    while (state_dbg !== st && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 64'(state_dbg), 64'(st));
  endtask

  task automatic count_state(input state_t st, input int maxc, output int n);
    n = 0;
    while (state_dbg === st && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic tag(input logic [4:0] ch);
    valid_tag = 1'b1;
    channel   = ch;
    tick();
    valid_tag = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"},  64'(state_dbg), 64'(ST_IDLE));
    check({pfx, "_idx"},    64'(slot_idx), 64'd0);
    check({pfx, "_failed"}, 64'(slot_failed), 64'd0);
    check({pfx, "_hold"},   64'(chk_hold), 64'd1);
    check({pfx, "_chsel"},  64'(chk_channel_select), 64'd0);
    check({pfx, "_lower"},  64'(chk_lower_bound), 64'h0033_0000);
    check({pfx, "_upper"},  64'(chk_upper_bound), 64'h0034_0000);
    check({pfx, "_busy"},   64'(busy), 64'd0);
    check({pfx, "_sweep"},  64'(sweep_done), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Sweep 1: both slots in bounds, one sweep_done pulse.
    slot_channel = {5'd1, 5'd0};
    slot_lower   = {32'd0, 32'd100};
    slot_upper   = {32'hFFFF_FFFF, 32'd200};
    dwell_tags   = 32'd3;
    tag_interval = 32'd150;
    enable       = 1'b1;
    tick();
    check("s1_load_state", 64'(state_dbg), 64'(ST_LOAD));
    check("s1_load_busy", 64'(busy), 64'd1);
    check("s1_load_hold", 64'(chk_hold), 64'd1);
    tick();
    check("s1_chsel0", 64'(chk_channel_select), 64'd0);
    check("s1_lower0", 64'(chk_lower_bound), 64'd100);
    check("s1_upper0", 64'(chk_upper_bound), 64'd200);
    count_state(ST_SETTLE, 20, n_cyc);
    check("s1_settle_len", 64'(n_cyc), 64'd6);
    check("s1_run_state", 64'(state_dbg), 64'(ST_RUN));
    check("s1_run_hold", 64'(chk_hold), 64'd0);
    tag(5'd0);
    tag(5'd1);
    check("s1_other_ch_ignored", 64'(state_dbg), 64'(ST_RUN));
    tag(5'd0);
    check("s1_two_of_three", 64'(state_dbg), 64'(ST_RUN));
    tag(5'd0);
    check("s1_capture_state", 64'(state_dbg), 64'(ST_CAPTURE));
    count_state(ST_CAPTURE, 20, n_cyc);
    check("s1_capture_len", 64'(n_cyc), 64'd3);
    check("s1_next_state", 64'(state_dbg), 64'(ST_NEXT));
    check("s1_slot0_result", 64'(slot_failed[31:0]), 64'd0);
    check("s1_no_sweep_slot0", 64'(sweep_done), 64'd0);
    tick();
    check("s1_slot1_idx", 64'(slot_idx), 64'd1);
    tick();
    check("s1_chsel1", 64'(chk_channel_select), 64'd1);
    check("s1_lower1", 64'(chk_lower_bound), 64'd0);
    check("s1_upper1", 64'(chk_upper_bound), 64'hFFFF_FFFF);
    wait_state(ST_RUN, 20, "s1_run1_reach");
    tag(5'd1);
    tag(5'd1);
    tag(5'd1);
    wait_state(ST_NEXT, 20, "s1_next1_reach");
    check("s1_sweep_done", 64'(sweep_done), 64'd1);
    check("s1_all_results", 64'(slot_failed), 64'd0);
    enable = 1'b0;
    tick();
    check("s1_idle_state", 64'(state_dbg), 64'(ST_IDLE));
    check("s1_idx_wrapped", 64'(slot_idx), 64'd0);
    check("s1_idle_busy", 64'(busy), 64'd0);
    check("s1_sweep_count", 64'(sweep_cnt), 64'd1);

    // Sweep 2: slot 0 out of bounds by 50.
    tag_interval = 32'd250;
    enable       = 1'b1;
    wait_state(ST_RUN, 20, "s2_run0_reach");
    tag(5'd0);
    tag(5'd0);
    tag(5'd0);
    wait_state(ST_NEXT, 20, "s2_next0_reach");
    check("s2_slot0_flag", 64'(slot_failed[31:0]), 64'h8000_0032);
    check("s2_slot1_clean", 64'(slot_failed[63:32]), 64'd0);

    // Abort in RUN of slot 1, then resume at slot 1.
    wait_state(ST_RUN, 20, "s3_run1_reach");
    enable = 1'b0;
    tick();
    check("s3_abort_state", 64'(state_dbg), 64'(ST_IDLE));
    check("s3_abort_hold", 64'(chk_hold), 64'd1);
    check("s3_abort_idx", 64'(slot_idx), 64'd1);
    check("s3_abort_keep", 64'(slot_failed[31:0]), 64'h8000_0032);
    tick();
    tick();
    dwell_tags = 32'd0;
    enable     = 1'b1;
    tick();
    check("s3_resume_state", 64'(state_dbg), 64'(ST_LOAD));
    check("s3_resume_idx", 64'(slot_idx), 64'd1);
    wait_state(ST_RUN, 20, "s4_run1_reach");
    dwell_tags = 32'd7;
    tag(5'd0);
    check("s4_other_ch", 64'(state_dbg), 64'(ST_RUN));
    tag(5'd1);
    check("s4_dwell0_done", 64'(state_dbg), 64'(ST_CAPTURE));
    dwell_tags = 32'd0;
    wait_state(ST_NEXT, 20, "s4_next1_reach");
    check("s4_sweep_done", 64'(sweep_done), 64'd1);
    check("s4_slot1_clean", 64'(slot_failed[63:32]), 64'd0);
    wait_state(ST_RUN, 20, "s4_run0_reach");
    tag(5'd0);
    check("s4_entry_tag", 64'(state_dbg), 64'(ST_CAPTURE));

    // Reset during CAPTURE.
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    check_reset_values("rst_capture");
    check("sweep_total", 64'(sweep_cnt), 64'd2);
    rst = 1'b0;
    tick();

`ifdef INTERVAL_SEQ_TIMEOUT_EN
    // RUN timeout with no tags on channel 0.
    timeout_cycles = 32'd50;
    dwell_tags     = 32'd3;
    enable         = 1'b1;
    wait_state(ST_RUN, 20, "to_run_reach");
    count_state(ST_RUN, 200, n_cyc);
    check("to_run_len", 64'(n_cyc), 64'd50);
    check("to_next_state", 64'(state_dbg), 64'(ST_NEXT));
    check("to_flag", 64'(slot_failed[31:0]), 64'h4000_0000);
    enable = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
